// File: rtl/hamming_accum_param.sv
// Sequential masked Hamming-distance accumulator with start/done framing.
// One CHUNK_W slice per accepted cycle; a threshold compare is produced in DONE.
module hamming_accum_param #(
  parameter int CHUNK_W  = 5,
  parameter int N_CYCLES = 3200,
  parameter int OUT_W    = $clog2(CHUNK_W*N_CYCLES+1),
  parameter int CNT_W    = $clog2(N_CYCLES+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [CHUNK_W-1:0] g_input,
  input  logic [CHUNK_W-1:0] e_input,
  input  logic [CHUNK_W-1:0] m_input,
  input  logic [OUT_W-1:0]   thresh,
  output logic [OUT_W-1:0]   o,
  output logic               busy,
  output logic               done,
  output logic               below_thresh
);

  localparam int PC_W = $clog2(CHUNK_W+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;

  logic [CHUNK_W-1:0] diff_s;
  logic [OUT_W-1:0]   sum_s;
  logic               last_s;

  function automatic logic [PC_W-1:0] popcount(input logic [CHUNK_W-1:0] v);
    logic [PC_W-1:0] acc;
    acc = {PC_W{1'b0}};
    for (int i = 0; i < CHUNK_W; i++) begin
      acc = acc + PC_W'(v[i]);
    end
    return acc;
  endfunction

  assign diff_s = (g_input ^ e_input) & ~m_input;
  assign sum_s  = o + OUT_W'(popcount(diff_s));
  // The accept that brings the count to N_CYCLES is the final one.
  assign last_s = (cnt_r == CNT_W'(N_CYCLES - 1));

  // Control FSM with the accumulator, counter and all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      o            <= {OUT_W{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
      below_thresh <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r      <= ACCUM;
            cnt_r        <= {CNT_W{1'b0}};
            o            <= {OUT_W{1'b0}};
            busy         <= 1'b1;
            done         <= 1'b0;
            below_thresh <= 1'b0;
          end
        end
        ACCUM: begin
          if (start) begin
            cnt_r <= {CNT_W{1'b0}};
            o     <= {OUT_W{1'b0}};
          end else if (in_valid) begin
            o     <= sum_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (last_s) begin
              state_r      <= DONE;
              busy         <= 1'b0;
              done         <= 1'b1;
              below_thresh <= (sum_s < thresh);
            end
          end
        end
        DONE: begin
          if (start) begin
            state_r      <= ACCUM;
            cnt_r        <= {CNT_W{1'b0}};
            o            <= {OUT_W{1'b0}};
            busy         <= 1'b1;
            done         <= 1'b0;
            below_thresh <= 1'b0;
          end else begin
            below_thresh <= (o < thresh);
          end
        end
        default: begin
          state_r      <= IDLE;
          cnt_r        <= {CNT_W{1'b0}};
          o            <= {OUT_W{1'b0}};
          busy         <= 1'b0;
          done         <= 1'b0;
          below_thresh <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/hamming_accum_param.md
Name: hamming_accum_param

Overview:
- Parametrised sequential Hamming-distance accumulator for garbled-circuit netlists.
- Each accepted cycle, it compares a CHUNK_W-bit slice of the garbler input against the evaluator input and adds the popcount of the masked XOR to a running total.
- After N_CYCLES accepted chunks it stops, holds the final distance and flags done, with a threshold-compare output.
- This is the next generation of the fixed-width hamming blocks. It adds a valid stall, a bit mask, explicit start/done framing and a threshold result.

Parameters:
- CHUNK_W, 5, bits compared per accepted cycle (1..64).
- N_CYCLES, 3200, chunks per comparison (>=1).
- OUT_W, $clog2(CHUNK_W*N_CYCLES+1), accumulator width; 14 at defaults.
- CNT_W, $clog2(N_CYCLES+1), chunk counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin a new comparison; clears the accumulator and counter.
- in_valid  in  1  g_input/e_input/m_input valid this cycle.
- g_input  in  CHUNK_W  garbler data slice.
- e_input  in  CHUNK_W  evaluator data slice.
- m_input  in  CHUNK_W  mask; 1 = ignore that bit position.
- thresh  in  OUT_W  threshold for the below_thresh result.
- o  out  OUT_W  running/final Hamming distance, registered.
- busy  out  1  high in ACCUM.
- done  out  1  high in DONE.
- below_thresh  out  1  in DONE: (o < thresh); 0 otherwise.

Behaviour:
- Reset (rst=0, async): state=IDLE, o=0, counter=0, busy=0, done=0, below_thresh=0. Reset asserted mid-ACCUM discards the partial sum immediately, without waiting for a clock.
- States: IDLE, ACCUM, DONE.
- IDLE: start=1 -> ACCUM, o<=0, cnt<=0. in_valid is ignored in IDLE and on the start cycle itself.
- ACCUM:
  - Accept occurs when in_valid=1 and start=0.
  - On accept: o <= o + popcount((g_input ^ e_input) & ~m_input), cnt <= cnt+1.
  - When an accept makes cnt == N_CYCLES -> DONE on the same edge. The last chunk is included in o.
  - in_valid=0: o and cnt hold (stall). No timeout.
  - start=1: restart, o<=0, cnt<=0, stay in ACCUM. Data in that cycle is dropped.
- DONE:
  - o holds; done=1; below_thresh registered as (o < thresh), updated every cycle so thresh may change.
  - in_valid is ignored.
  - start=1 -> ACCUM with o and cnt cleared, done<=0.
- Latency: o reflects a chunk one clock after its accept edge. done and below_thresh are valid the cycle after the final accept. below_thresh uses the final o, not a pre-add value.
- Arithmetic:
  - Popcount is a pure adder tree, CHUNK_W-bit input, $clog2(CHUNK_W+1)-bit result, zero-extended to OUT_W.
  - Overflow is impossible by construction of OUT_W. No saturation logic.
- Mask all ones: the chunk contributes 0 but still counts toward N_CYCLES.
- Counter wraps never: cnt never exceeds N_CYCLES.
- Outputs are registered directly, with no combinational path from inputs to o/done.
- Datapath must be XOR/AND-heavy and flat so synthesis to the garbled-circuit gate library (XOR/XNOR/ANDN/MUX/DFF) is cheap. No multipliers, no memories.

Test Plan:
- Reset/idle: CHUNK_W=5, N_CYCLES=4. Hold rst=0, then release; drive in_valid=1 with g=5'h1F, e=0 and no start -> o=0, busy=0, done=0 throughout.
- Full run, defaults of small config (CHUNK_W=5, N_CYCLES=4):
  - start, then 4 valid chunks (g,e,m) = (1F,00,00), (15,0A,00), (00,00,00), (1F,1F,00).
  - o = 5, 10, 10, 10 after each accept.
  - done=1 the cycle after the 4th accept.
  - thresh=11 -> below_thresh=1; thresh=10 -> below_thresh=0.
- Stall + mask:
  - Same config. Chunks (1F,00,03), bubble of 3 cycles with in_valid=0, then (1F,00,1F), (07,00,00), (01,00,00).
  - o: 3, holds 3 during the bubble, then 3, 6, 7; done after the 4th accept only.
- Restart mid-run: after 2 accepts (o=10), pulse start with in_valid=1 -> o=0, cnt=0, that cycle's data dropped; 4 further chunks are required before done.
- Async reset mid-ACCUM: assert rst=0 between clock edges with o=7 -> o=0, busy=0 immediately. After release, the block is idle until start.
- Defaults (CHUNK_W=5, N_CYCLES=3200): 3200 chunks of g=1F, e=00 -> o=16000 (14'h3E80), done=1 after exactly 3200 accepts, no overflow.
